// File: rtl/star_box_finder_if.sv
// star_box_finder_if: bundles the go/done handshake, frame-buffer read port and erase-stage box hand-off.
interface star_box_finder_if #(
    parameter int XSZ    = 8,
    parameter int YSZ    = 7,
    parameter int COLSZ  = 3,
    parameter int ADDRSZ = 15
);
    logic              i_go_find;
    logic              o_done_find;
    logic              o_busy;
    logic [ADDRSZ-1:0] o_rd_addr;
    logic [COLSZ-1:0]  i_rd_data;
    logic [XSZ-1:0]    o_x_left;
    logic [XSZ-1:0]    o_x_right;
    logic [YSZ-1:0]    o_y_top;
    logic [YSZ-1:0]    o_y_bottom;
    logic              o_go_clean;
    logic              i_done_clean;
    logic [7:0]        o_star_count;

    modport slave (
        input  i_go_find, i_rd_data, i_done_clean,
        output o_done_find, o_busy, o_rd_addr, o_x_left, o_x_right,
               o_y_top, o_y_bottom, o_go_clean, o_star_count
    );

    modport master (
        output i_go_find, i_rd_data, i_done_clean,
        input  o_done_find, o_busy, o_rd_addr, o_x_left, o_x_right,
               o_y_top, o_y_bottom, o_go_clean, o_star_count
    );
endinterface

// File: rtl/star_box_finder.sv
// star_box_finder: raster-scans the frame buffer, measures a cross-extent box around each
// bright seed pixel, hands it to the erase stage and resumes the scan once it is cleared.
module star_box_finder #(
    parameter int XSZ    = 8,
    parameter int YSZ    = 7,
    parameter int COLSZ  = 3,
    parameter int ADDRSZ = 15,
    parameter int XMAX   = 159,
    parameter int YMAX   = 119
) (
    input  logic                  clk,
    input  logic                  resetn,
    star_box_finder_if.slave      bus
);
    typedef enum logic [3:0] {
        IDLE, SCAN_RD, SCAN_CHK, RIGHT_RD, RIGHT_CHK, LEFT_RD, LEFT_CHK,
        DOWN_RD, DOWN_CHK, ISSUE, WAIT_CLEAN, DONE
    } state_t;

    localparam logic [XSZ-1:0] XM = XSZ'(XMAX);
    localparam logic [YSZ-1:0] YM = YSZ'(YMAX);

    state_t         r_state;
    logic [XSZ-1:0] r_sx, r_px, r_x_left, r_x_right;
    logic [YSZ-1:0] r_sy, r_py, r_y_top, r_y_bottom;
    logic [7:0]     r_star_count;
    logic           r_go_clean, r_done_find;

    logic           w_bright;
    state_t         w_after_left, w_after_right;
    logic [XSZ-1:0] w_ax;
    logic [YSZ-1:0] w_ay;

    always_comb begin
        w_bright      = |bus.i_rd_data;
        w_after_left  = (r_sy != YM) ? DOWN_RD : ISSUE;
        w_after_right = (r_sx != '0) ? LEFT_RD : w_after_left;
        w_ay          = (r_state == DOWN_RD) ? r_py : r_sy;
        w_ax          = (r_state == RIGHT_RD || r_state == LEFT_RD) ? r_px : r_sx;
    end

    // y*160 + x without a multiplier
    assign bus.o_rd_addr    = (ADDRSZ'(w_ay) << 7) + (ADDRSZ'(w_ay) << 5) + ADDRSZ'(w_ax);
    assign bus.o_x_left     = r_x_left;
    assign bus.o_x_right    = r_x_right;
    assign bus.o_y_top      = r_y_top;
    assign bus.o_y_bottom   = r_y_bottom;
    assign bus.o_go_clean   = r_go_clean;
    assign bus.o_done_find  = r_done_find;
    assign bus.o_star_count = r_star_count;
    assign bus.o_busy       = !(r_state == IDLE || r_state == DONE);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_sx         <= '0;
            r_sy         <= '0;
            r_px         <= '0;
            r_py         <= '0;
            r_x_left     <= '0;
            r_x_right    <= '0;
            r_y_top      <= '0;
            r_y_bottom   <= '0;
            r_star_count <= '0;
            r_go_clean   <= 1'b0;
            r_done_find  <= 1'b0;
        end else begin
            r_go_clean  <= 1'b0;
            r_done_find <= 1'b0;
            case (r_state)
                IDLE, DONE: if (bus.i_go_find) begin
                    r_star_count <= '0;
                    r_sx         <= '0;
                    r_sy         <= '0;
                    r_state      <= SCAN_RD;
                end
                SCAN_RD: r_state <= SCAN_CHK;
                SCAN_CHK: if (w_bright) begin
                    r_x_left     <= r_sx;
                    r_x_right    <= r_sx;
                    r_y_top      <= r_sy;
                    r_y_bottom   <= r_sy;
                    r_star_count <= r_star_count + 8'(r_star_count != 8'hFF);
                    // probe set up for whichever directional scan comes first; edges guard every step
                    r_px         <= (r_sx != XM) ? r_sx + 1'b1 : r_sx - XSZ'(r_sx != '0);
                    r_py         <= r_sy + YSZ'(r_sy != YM);
                    r_state      <= (r_sx != XM) ? RIGHT_RD : w_after_right;
                    r_go_clean   <= (r_sx == XM) && (w_after_right == ISSUE);
                end else if (r_sx != XM) begin
                    r_sx    <= r_sx + 1'b1;
                    r_state <= SCAN_RD;
                end else if (r_sy != YM) begin
                    r_sx    <= '0;
                    r_sy    <= r_sy + 1'b1;
                    r_state <= SCAN_RD;
                end else begin
                    r_state     <= DONE;
                    r_done_find <= 1'b1;
                end
                RIGHT_RD: r_state <= RIGHT_CHK;
                RIGHT_CHK: begin
                    if (w_bright)
                        r_x_right <= r_px;
                    if (w_bright && r_px != XM) begin
                        r_px    <= r_px + 1'b1;
                        r_state <= RIGHT_RD;
                    end else begin
                        r_px       <= r_sx - XSZ'(r_sx != '0);
                        r_state    <= w_after_right;
                        r_go_clean <= (w_after_right == ISSUE);
                    end
                end
                LEFT_RD: r_state <= LEFT_CHK;
                LEFT_CHK: begin
                    if (w_bright)
                        r_x_left <= r_px;
                    if (w_bright && r_px != '0) begin
                        r_px    <= r_px - 1'b1;
                        r_state <= LEFT_RD;
                    end else begin
                        r_state    <= w_after_left;
                        r_go_clean <= (w_after_left == ISSUE);
                    end
                end
                DOWN_RD: r_state <= DOWN_CHK;
                DOWN_CHK: begin
                    if (w_bright)
                        r_y_bottom <= r_py;
                    if (w_bright && r_py != YM) begin
                        r_py    <= r_py + 1'b1;
                        r_state <= DOWN_RD;
                    end else begin
                        r_state    <= ISSUE;
                        r_go_clean <= 1'b1;
                    end
                end
                ISSUE: r_state <= WAIT_CLEAN;
                // seed pixel is black after the erase, so rescanning it cannot re-detect
                WAIT_CLEAN: if (bus.i_done_clean) r_state <= SCAN_RD;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_star_box_finder.sv
// tb_star_box_finder: directed frames against a RAM model and an erase-stage model.
module tb_star_box_finder;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    star_box_finder_if #(.XSZ(8), .YSZ(7), .COLSZ(3), .ADDRSZ(15)) bus ();
    star_box_finder dut (.clk(clk), .resetn(resetn), .bus(bus));

    logic [2:0] mem [0:19199];
    int n_cmp = 0, n_bad = 0, max_addr = 0;
    int cycles;
    bit done_seen;
    int bx_l[$], bx_r[$], by_t[$], by_b[$];

    always @(posedge clk) begin
        bus.i_rd_data <= (bus.o_rd_addr < 15'd19200) ? mem[bus.o_rd_addr] : 3'd0;
        if (bus.o_busy && int'(bus.o_rd_addr) > max_addr)
            max_addr <= int'(bus.o_rd_addr);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 19200; i++) mem[i] = 3'd0;
    endtask

    task automatic run_frame(input bit hold, input bit stop_at_clean);
        bx_l.delete(); bx_r.delete(); by_t.delete(); by_b.delete();
        cycles = 0;
        done_seen = 1'b0;
        bus.i_go_find = 1'b1;
        while (cycles < 60000) begin
            @(posedge clk); #1;
            cycles++;
            if (!hold) bus.i_go_find = 1'b0;
            if (bus.o_done_find) begin
                done_seen = 1'b1;
                bus.i_go_find = 1'b0;
                break;
            end
            if (bus.o_go_clean) begin
                bx_l.push_back(int'(bus.o_x_left));
                bx_r.push_back(int'(bus.o_x_right));
                by_t.push_back(int'(bus.o_y_top));
                by_b.push_back(int'(bus.o_y_bottom));
                if (stop_at_clean) return;
                for (int y = int'(bus.o_y_top); y <= int'(bus.o_y_bottom); y++)
                    for (int x = int'(bus.o_x_left); x <= int'(bus.o_x_right); x++)
                        mem[y*160 + x] = 3'd0;
                repeat (3) @(posedge clk);
                #1 bus.i_done_clean = 1'b1;
                @(posedge clk);
                #1 bus.i_done_clean = 1'b0;
                cycles += 4;
            end
        end
        bus.i_go_find = 1'b0;
    endtask

    initial begin
        bus.i_go_find = 1'b0;
        bus.i_done_clean = 1'b0;
        clear_mem();
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", int'(bus.o_busy), 0);
        check("rst count", int'(bus.o_star_count), 0);
        check("rst goclean", int'(bus.o_go_clean), 0);
        check("rst donefind", int'(bus.o_done_find), 0);
        check("rst addr", int'(bus.o_rd_addr), 0);
        check("rst xright", int'(bus.o_x_right), 0);
        resetn = 1'b1;

        // blank frame
        run_frame(1'b0, 1'b0);
        check("t1 done", int'(done_seen), 1);
        check("t1 cycles", cycles, 38401);
        check("t1 count", int'(bus.o_star_count), 0);
        check("t1 boxes", bx_l.size(), 0);
        @(posedge clk); #1;
        check("t1 pulse", int'(bus.o_done_find), 0);
        check("t1 busy", int'(bus.o_busy), 0);

        // single pixel
        mem[5*160 + 10] = 3'b101;
        run_frame(1'b0, 1'b0);
        check("t2 done", int'(done_seen), 1);
        check("t2 boxes", bx_l.size(), 1);
        if (bx_l.size() == 1) begin
            check("t2 xl", bx_l[0], 10); check("t2 xr", bx_r[0], 10);
            check("t2 yt", by_t[0], 5);  check("t2 yb", by_b[0], 5);
        end
        check("t2 count", int'(bus.o_star_count), 1);

        // 3x3 star
        for (int y = 30; y <= 32; y++)
            for (int x = 20; x <= 22; x++) mem[y*160 + x] = 3'd6;
        run_frame(1'b0, 1'b0);
        check("t3 boxes", bx_l.size(), 1);
        if (bx_l.size() == 1) begin
            check("t3 xl", bx_l[0], 20); check("t3 xr", bx_r[0], 22);
            check("t3 yt", by_t[0], 30); check("t3 yb", by_b[0], 32);
        end
        check("t3 count", int'(bus.o_star_count), 1);

        // corner stars
        mem[0] = 3'd1;
        for (int y = 118; y <= 119; y++)
            for (int x = 158; x <= 159; x++) mem[y*160 + x] = 3'd4;
        run_frame(1'b0, 1'b0);
        check("t4 done", int'(done_seen), 1);
        check("t4 boxes", bx_l.size(), 2);
        if (bx_l.size() == 2) begin
            check("t4 b0 xl", bx_l[0], 0);   check("t4 b0 xr", bx_r[0], 0);
            check("t4 b0 yt", by_t[0], 0);   check("t4 b0 yb", by_b[0], 0);
            check("t4 b1 xl", bx_l[1], 158); check("t4 b1 xr", bx_r[1], 159);
            check("t4 b1 yt", by_t[1], 118); check("t4 b1 yb", by_b[1], 119);
        end
        check("t4 count", int'(bus.o_star_count), 2);
        check("t4 addr range", int'(max_addr <= 19199), 1);

        // reset while waiting for the erase
        mem[5*160 + 10] = 3'd3;
        run_frame(1'b0, 1'b1);
        check("t5 goclean seen", bx_l.size(), 1);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("t5 busy", int'(bus.o_busy), 0);
        check("t5 count", int'(bus.o_star_count), 0);
        check("t5 goclean", int'(bus.o_go_clean), 0);
        check("t5 xleft", int'(bus.o_x_left), 0);
        resetn = 1'b1;
        @(posedge clk); #1 bus.i_done_clean = 1'b1;
        @(posedge clk); #1 bus.i_done_clean = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t5 stray done busy", int'(bus.o_busy), 0);
        bus.i_go_find = 1'b1;
        @(posedge clk); #1 bus.i_go_find = 1'b0;
        check("t5 restart busy", int'(bus.o_busy), 1);
        check("t5 restart addr", int'(bus.o_rd_addr), 0);
        run_frame(1'b0, 1'b0);
        check("t5 done", int'(done_seen), 1);
        check("t5 final count", int'(bus.o_star_count), 1);

        // goFind held high throughout the scan
        mem[5*160 + 10] = 3'd2;
        mem[100*160 + 30] = 3'd7;
        run_frame(1'b1, 1'b0);
        check("t6 done", int'(done_seen), 1);
        check("t6 boxes", bx_l.size(), 2);
        if (bx_l.size() == 2) begin
            check("t6 b1 xl", bx_l[1], 30);
            check("t6 b1 yt", by_t[1], 100);
        end
        check("t6 count", int'(bus.o_star_count), 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
